// File: rtl/islemci_trafik_uretici_pkg.sv
// Shared types, widths and the test-pattern helper for the processor-side traffic generator.
package islemci_trafik_pkg;

   localparam int unsigned VERI_W        = 32;
   localparam int unsigned ADRES_W       = 32;
   localparam int unsigned HATA_SAYISI_W = 16;

   typedef enum logic [2:0] {
      BOSTA,
      YAZ,
      OKU_ISTEK,
      OKU_BEKLE,
      BITTI
   } durum_e;

   typedef struct packed {
      logic [ADRES_W-1:0] adres;
      logic [VERI_W-1:0]  veri;
      logic               yaz;
   } istek_t;

   // Pattern word for index i: 32-bit modulo sum, word aligned.
   function automatic logic [VERI_W-1:0] beklenen_veri(input logic [VERI_W-1:0]  taban,
                                                       input logic [ADRES_W-1:0] i);
      logic [VERI_W-1:0] toplam;
      toplam = taban + i;
      return toplam & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/islemci_trafik_uretici_if.sv
// Request/response bus between the traffic generator (master) and the cache (slave).
interface islemci_trafik_uretici_if;
   import islemci_trafik_pkg::*;

   logic [ADRES_W-1:0] istek_adres_o;
   logic [VERI_W-1:0]  istek_veri_o;
   logic               istek_gecerli_o;
   logic               istek_yaz_o;
   logic               istek_hazir_i;
   logic [VERI_W-1:0]  cevap_veri_i;
   logic               cevap_gecerli_i;
   logic               cevap_hazir_o;

   modport master (
      output istek_adres_o, istek_veri_o, istek_gecerli_o, istek_yaz_o, cevap_hazir_o,
      input  istek_hazir_i, cevap_veri_i, cevap_gecerli_i
   );

   modport slave (
      input  istek_adres_o, istek_veri_o, istek_gecerli_o, istek_yaz_o, cevap_hazir_o,
      output istek_hazir_i, cevap_veri_i, cevap_gecerli_i
   );

endinterface

// File: rtl/islemci_trafik_uretici_cevap_denetleyici.sv
// Read-response checker: compares returned data with the pattern and keeps the error flag,
// saturating error count, first failing index and the read-timeout counter.
module cevap_denetleyici
   import islemci_trafik_pkg::*;
#(
   parameter logic [VERI_W-1:0] DESEN_TABAN = 32'hABCD_0000,
   parameter int unsigned       ZAMAN_ASIMI = 1024
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     temizle_i,
   input  logic                     bekle_i,
   input  logic                     zaman_temizle_i,
   input  logic                     cevap_al_i,
   input  logic [VERI_W-1:0]        cevap_veri_i,
   input  logic [ADRES_W-1:0]       indeks_i,
   output logic                     zaman_doldu_c_o,
   output logic                     hata_o,
   output logic [HATA_SAYISI_W-1:0] hata_sayisi_o,
   output logic [ADRES_W-1:0]       ilk_hata_adres_o,
   output logic                     zaman_asimi_o
);

   localparam int unsigned ZW = $clog2(ZAMAN_ASIMI + 1);

   logic [ZW-1:0]            zaman_q;
   logic                     hata_q;
   logic                     zaman_asimi_q;
   logic [HATA_SAYISI_W-1:0] hata_sayisi_q;
   logic [ADRES_W-1:0]       ilk_hata_q;
   logic                     uyusmazlik_c;
   logic                     hata_olay_c;

   assign uyusmazlik_c = cevap_al_i && (cevap_veri_i != beklenen_veri(DESEN_TABAN, indeks_i));
   // A response arriving on the expiry edge wins over the timeout.
   assign zaman_doldu_c_o = bekle_i && !cevap_al_i && (zaman_q == ZW'(ZAMAN_ASIMI - 1));
   assign hata_olay_c     = uyusmazlik_c || zaman_doldu_c_o;

   always_ff @(posedge clk_i) begin
      if (rst_i || temizle_i) begin
         zaman_q       <= '0;
         hata_q        <= 1'b0;
         zaman_asimi_q <= 1'b0;
         hata_sayisi_q <= '0;
         ilk_hata_q    <= '0;
      end else begin
         if (zaman_temizle_i) begin
            zaman_q <= '0;
         end else if (bekle_i && !cevap_al_i && !zaman_doldu_c_o) begin
            zaman_q <= zaman_q + ZW'(1);
         end
         if (hata_olay_c) begin
            hata_q <= 1'b1;
            if (hata_sayisi_q != '1) begin
               hata_sayisi_q <= hata_sayisi_q + HATA_SAYISI_W'(1);
            end
            if (!hata_q) begin
               ilk_hata_q <= indeks_i;
            end
         end
         if (zaman_doldu_c_o) begin
            zaman_asimi_q <= 1'b1;
         end
      end
   end

   assign hata_o           = hata_q;
   assign hata_sayisi_o    = hata_sayisi_q;
   assign ilk_hata_adres_o = ilk_hata_q;
   assign zaman_asimi_o    = zaman_asimi_q;

endmodule

// File: rtl/islemci_trafik_uretici.sv
// Processor-side traffic generator: writes a pattern over TEST_LEN addresses, reads it back
// one outstanding read at a time, and reports completion and errors.
module islemci_trafik_uretici
   import islemci_trafik_pkg::*;
#(
   parameter int unsigned       TEST_LEN    = 16384,
   parameter logic [VERI_W-1:0] DESEN_TABAN = 32'hABCD_0000,
   parameter int unsigned       ZAMAN_ASIMI = 1024
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     baslat_i,
   islemci_trafik_uretici_if.master bus,
   output logic                     bitti_o,
   output logic                     hata_o,
   output logic [HATA_SAYISI_W-1:0] hata_sayisi_o,
   output logic [ADRES_W-1:0]       ilk_hata_adres_o,
   output logic                     zaman_asimi_o
);

   localparam int unsigned IW = $clog2(TEST_LEN) + 1;

   durum_e        durum_q;
   logic [IW-1:0] i_q;
   istek_t        istek_q;
   logic          gecerli_q;
   logic          bitti_q;
   logic          cevap_hazir_q;

   logic [IW-1:0] i_sonraki_c;
   logic          son_c;
   logic          istek_kabul_c;
   logic          cevap_al_c;
   logic          temizle_c;
   logic          zaman_doldu_c;

   assign i_sonraki_c   = i_q + IW'(1);
   assign son_c         = (i_q == IW'(TEST_LEN - 1));
   assign istek_kabul_c = gecerli_q && bus.istek_hazir_i;
   assign cevap_al_c    = (durum_q == OKU_BEKLE) && bus.cevap_gecerli_i && cevap_hazir_q;
   assign temizle_c     = ((durum_q == BOSTA) || (durum_q == BITTI)) && baslat_i;

   // Sequencer and request path; request fields only change on acceptance or state entry.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         durum_q       <= BOSTA;
         i_q           <= '0;
         istek_q       <= '0;
         gecerli_q     <= 1'b0;
         bitti_q       <= 1'b0;
         cevap_hazir_q <= 1'b0;
      end else begin
         cevap_hazir_q <= 1'b1;
         case (durum_q)
            BOSTA, BITTI: begin
               if (baslat_i) begin
                  durum_q       <= YAZ;
                  i_q           <= '0;
                  gecerli_q     <= 1'b1;
                  bitti_q       <= 1'b0;
                  istek_q.adres <= '0;
                  istek_q.veri  <= beklenen_veri(DESEN_TABAN, '0);
                  istek_q.yaz   <= 1'b1;
               end
            end
            YAZ: begin
               if (istek_kabul_c) begin
                  if (son_c) begin
                     durum_q       <= OKU_ISTEK;
                     i_q           <= '0;
                     istek_q.adres <= '0;
                     istek_q.veri  <= '0;
                     istek_q.yaz   <= 1'b0;
                  end else begin
                     i_q           <= i_sonraki_c;
                     istek_q.adres <= ADRES_W'(i_sonraki_c);
                     istek_q.veri  <= beklenen_veri(DESEN_TABAN, ADRES_W'(i_sonraki_c));
                  end
               end
            end
            OKU_ISTEK: begin
               if (istek_kabul_c) begin
                  durum_q   <= OKU_BEKLE;
                  gecerli_q <= 1'b0;
               end
            end
            OKU_BEKLE: begin
               if (cevap_al_c) begin
                  if (son_c) begin
                     durum_q <= BITTI;
                     bitti_q <= 1'b1;
                  end else begin
                     durum_q       <= OKU_ISTEK;
                     i_q           <= i_sonraki_c;
                     gecerli_q     <= 1'b1;
                     istek_q.adres <= ADRES_W'(i_sonraki_c);
                  end
               end else if (zaman_doldu_c) begin
                  durum_q <= BITTI;
                  bitti_q <= 1'b1;
               end
            end
            default: begin
               durum_q   <= BOSTA;
               gecerli_q <= 1'b0;
            end
         endcase
      end
   end

   cevap_denetleyici #(
      .DESEN_TABAN (DESEN_TABAN),
      .ZAMAN_ASIMI (ZAMAN_ASIMI)
   ) u_cevap_denetleyici (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .temizle_i        (temizle_c),
      .bekle_i          (durum_q == OKU_BEKLE),
      .zaman_temizle_i  ((durum_q == OKU_ISTEK) && istek_kabul_c),
      .cevap_al_i       (cevap_al_c),
      .cevap_veri_i     (bus.cevap_veri_i),
      .indeks_i         (ADRES_W'(i_q)),
      .zaman_doldu_c_o  (zaman_doldu_c),
      .hata_o           (hata_o),
      .hata_sayisi_o    (hata_sayisi_o),
      .ilk_hata_adres_o (ilk_hata_adres_o),
      .zaman_asimi_o    (zaman_asimi_o)
   );

   assign bus.istek_adres_o   = istek_q.adres;
   assign bus.istek_veri_o    = istek_q.veri;
   assign bus.istek_yaz_o     = istek_q.yaz;
   assign bus.istek_gecerli_o = gecerli_q;
   assign bus.cevap_hazir_o   = cevap_hazir_q;
   assign bitti_o             = bitti_q;

endmodule

// File: tb/tb_islemci_trafik_uretici.sv
// Bench for islemci_trafik_uretici: randomized cache responder with a memory model, protocol
// monitors and a result model derived from the corrupted/silent address set.
module tb_islemci_trafik_uretici;

   localparam int TL = 16;
   localparam logic [31:0] TABAN = 32'hABCD_0000;
   // Larger than the slowest random response so only the silent-address case times out.
   localparam int ZA = 24;

   logic        clk    = 1'b0;
   logic        rst    = 1'b1;
   logic        baslat = 1'b0;
   logic        bitti, hata, zaman;
   logic [15:0] sayi;
   logic [31:0] ilk;

   islemci_trafik_uretici_if bus ();

   islemci_trafik_uretici #(
      .TEST_LEN    (TL),
      .DESEN_TABAN (TABAN),
      .ZAMAN_ASIMI (ZA)
   ) dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .baslat_i         (baslat),
      .bus              (bus),
      .bitti_o          (bitti),
      .hata_o           (hata),
      .hata_sayisi_o    (sayi),
      .ilk_hata_adres_o (ilk),
      .zaman_asimi_o    (zaman)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Responder configuration
   int          hazir_oran, gec_max, yabanci_oran, baslat_oran, cevapsiz, reset_adr;
   bit          bozuk [TL];
   logic [31:0] bozuk_veri [TL];
   logic [31:0] mem [TL];

   // Observations of one run
   int          wr_adr[$];
   logic [31:0] wr_dat[$];
   int          wr_cyc[$];
   int          rd_adr[$];
   int          kararsiz, fazla_okuma, okuma_veri_hata, son_cyc, cevapsiz_kabul_cyc;
   bit          bitti_gordu;

   int          e_adet, e_ilk;
   bit          e_zaman;

   function automatic logic [31:0] beklenen(input int i);
      logic [31:0] t;
      t = TABAN + 32'(i);
      return t & 32'hFFFF_FFFC;
   endfunction

   // Reads proceed in order and stop at the first silent address.
   function automatic void model_sonuc(output int adet, output int ilk_a, output bit zm);
      adet = 0; ilk_a = 0; zm = 1'b0;
      for (int a = 0; a < TL; a++) begin
         if (a == cevapsiz) begin
            adet++; if (adet == 1) ilk_a = a; zm = 1'b1;
            break;
         end
         if (bozuk[a] && bozuk_veri[a] !== beklenen(a)) begin
            adet++; if (adet == 1) ilk_a = a;
         end
      end
   endfunction

   task automatic ayar_sifirla();
      hazir_oran = 100; gec_max = 0; yabanci_oran = 0; baslat_oran = 0;
      cevapsiz = -1; reset_adr = -1;
      for (int a = 0; a < TL; a++) begin
         bozuk[a] = 1'b0; bozuk_veri[a] = '0; mem[a] = $urandom;
      end
   endtask

   task automatic baslat_ver();
      @(negedge clk); baslat = 1'b1;
      @(negedge clk); baslat = 1'b0;
   endtask

   // Cycle-by-cycle responder; samples at negedge and predicts the following posedge's transfers.
   task automatic calistir(input int max_cyc);
      bit          bekliyor, bek_once, onceki_tut, onc_yaz;
      int          bek_adr, gecikme;
      logic [31:0] onc_adr, onc_veri;
      wr_adr.delete(); wr_dat.delete(); wr_cyc.delete(); rd_adr.delete();
      kararsiz = 0; fazla_okuma = 0; okuma_veri_hata = 0;
      son_cyc = -1; cevapsiz_kabul_cyc = -1; bitti_gordu = 1'b0;
      bekliyor = 1'b0; onceki_tut = 1'b0; bek_adr = -1; gecikme = 0;
      onc_yaz = 1'b0; onc_adr = '0; onc_veri = '0;
      for (int cyc = 0; cyc < max_cyc; cyc++) begin
         @(negedge clk);
         if (bitti === 1'b1) begin
            bitti_gordu = 1'b1; son_cyc = cyc;
            break;
         end
         if (onceki_tut && (bus.istek_gecerli_o !== 1'b1 || bus.istek_adres_o !== onc_adr ||
                            bus.istek_veri_o !== onc_veri || bus.istek_yaz_o !== onc_yaz))
            kararsiz++;
         if (reset_adr >= 0 && bus.istek_gecerli_o === 1'b1 && bus.istek_yaz_o === 1'b0 &&
             bus.istek_adres_o === 32'(reset_adr)) begin
            rst = 1'b1;
            break;
         end
         bus.istek_hazir_i = (int'($urandom_range(0, 99)) < hazir_oran);
         baslat = (int'($urandom_range(0, 99)) < baslat_oran);
         bus.cevap_veri_i = $urandom;
         bus.cevap_gecerli_i = 1'b0;
         if (bekliyor && gecikme == 0 && bek_adr != cevapsiz) begin
            bus.cevap_gecerli_i = 1'b1;
            bus.cevap_veri_i = bozuk[bek_adr] ? bozuk_veri[bek_adr] : mem[bek_adr];
         end else if (bekliyor) begin
            if (gecikme > 0) gecikme--;
         end else if (int'($urandom_range(0, 99)) < yabanci_oran) begin
            bus.cevap_gecerli_i = 1'b1;
         end
         bek_once = bekliyor;
         if (bek_once && bus.istek_gecerli_o === 1'b1) fazla_okuma++;
         if (bus.cevap_gecerli_i && bus.cevap_hazir_o === 1'b1) bekliyor = 1'b0;
         if (bus.istek_gecerli_o === 1'b1 && bus.istek_hazir_i) begin
            if (bus.istek_yaz_o === 1'b1) begin
               wr_adr.push_back(int'(bus.istek_adres_o));
               wr_dat.push_back(bus.istek_veri_o);
               wr_cyc.push_back(cyc);
               if (bus.istek_adres_o < 32'(TL)) mem[bus.istek_adres_o[3:0]] = bus.istek_veri_o;
            end else begin
               rd_adr.push_back(int'(bus.istek_adres_o));
               if (bus.istek_veri_o !== 32'h0) okuma_veri_hata++;
               bekliyor = 1'b1;
               bek_adr  = int'(bus.istek_adres_o);
               gecikme  = int'($urandom_range(0, gec_max));
               if (bek_adr == cevapsiz) cevapsiz_kabul_cyc = cyc;
            end
         end
         onceki_tut = (bus.istek_gecerli_o === 1'b1) && !bus.istek_hazir_i;
         onc_adr = bus.istek_adres_o; onc_veri = bus.istek_veri_o; onc_yaz = bus.istek_yaz_o;
      end
      bus.istek_hazir_i = 1'b0; bus.cevap_gecerli_i = 1'b0; baslat = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({bus.istek_gecerli_o, bus.istek_yaz_o, bus.cevap_hazir_o, bitti, hata, zaman} !== 6'b0) begin
         failures++;
         $display("FAIL reset_flags got=%b%b%b%b%b%b exp=000000", bus.istek_gecerli_o,
                  bus.istek_yaz_o, bus.cevap_hazir_o, bitti, hata, zaman);
      end
      checks++;
      if (bus.istek_adres_o !== 32'h0 || bus.istek_veri_o !== 32'h0 || sayi !== 16'h0 || ilk !== 32'h0) begin
         failures++;
         $display("FAIL reset_values got adr=%h veri=%h sayi=%h ilk=%h exp all 0",
                  bus.istek_adres_o, bus.istek_veri_o, sayi, ilk);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.cevap_hazir_o !== 1'b1) begin
         failures++; $display("FAIL reset_cevap_hazir got=%b exp=1", bus.cevap_hazir_o);
      end
      checks++;
      if (bus.istek_gecerli_o !== 1'b0 || bitti !== 1'b0) begin
         failures++; $display("FAIL idle_after_reset got gecerli=%b bitti=%b exp 0 0", bus.istek_gecerli_o, bitti);
      end
   endtask

   task automatic test_ideal();
      ayar_sifirla();
      baslat_ver();
      calistir(400);
      model_sonuc(e_adet, e_ilk, e_zaman);
      checks++;
      if (!bitti_gordu) begin failures++; $display("FAIL ideal_done got=0 exp=1 (cycle budget)"); end
      checks++;
      if (wr_adr.size() != TL || rd_adr.size() != TL) begin
         failures++; $display("FAIL ideal_counts got wr=%0d rd=%0d exp %0d", wr_adr.size(), rd_adr.size(), TL);
      end
      checks++;
      if (wr_cyc.size() == TL && wr_cyc[TL-1] - wr_cyc[0] != TL - 1) begin
         failures++; $display("FAIL ideal_back_to_back got span=%0d exp=%0d", wr_cyc[TL-1] - wr_cyc[0], TL - 1);
      end
      for (int k = 0; k < wr_adr.size(); k++) begin
         checks++;
         if (wr_adr[k] != k || wr_dat[k] !== beklenen(k)) begin
            failures++; $display("FAIL ideal_write[%0d] got adr=%0d dat=%h exp adr=%0d dat=%h",
                                 k, wr_adr[k], wr_dat[k], k, beklenen(k));
         end
      end
      checks++;
      if (hata !== 1'b0 || sayi !== 16'(e_adet) || ilk !== 32'(e_ilk) || zaman !== e_zaman) begin
         failures++; $display("FAIL ideal_result got hata=%b sayi=%0d ilk=%0d zaman=%b exp 0 %0d %0d %b",
                              hata, sayi, ilk, zaman, e_adet, e_ilk, e_zaman);
      end
      repeat (5) @(negedge clk);
      checks++;
      if (bitti !== 1'b1 || bus.istek_gecerli_o !== 1'b0) begin
         failures++; $display("FAIL ideal_hold got bitti=%b gecerli=%b exp 1 0", bitti, bus.istek_gecerli_o);
      end
   endtask

   task automatic test_bozuk();
      ayar_sifirla();
      bozuk[5] = 1'b1; bozuk_veri[5] = 32'hDEAD_BEEF;
      bozuk[9] = 1'b1; bozuk_veri[9] = 32'h0000_0000;
      baslat_ver();
      calistir(400);
      model_sonuc(e_adet, e_ilk, e_zaman);
      checks++;
      if (!bitti_gordu || rd_adr.size() != TL) begin
         failures++; $display("FAIL corrupt_done got bitti=%b rd=%0d exp 1 %0d", bitti_gordu, rd_adr.size(), TL);
      end
      checks++;
      if (hata !== 1'b1 || sayi !== 16'(e_adet)) begin
         failures++; $display("FAIL corrupt_count got hata=%b sayi=%0d exp 1 %0d", hata, sayi, e_adet);
      end
      checks++;
      if (ilk !== 32'(e_ilk) || zaman !== 1'b0) begin
         failures++; $display("FAIL corrupt_first got ilk=%0d zaman=%b exp %0d 0", ilk, zaman, e_ilk);
      end
   endtask

   task automatic test_random();
      for (int r = 0; r < 3; r++) begin
         ayar_sifirla();
         hazir_oran = 30; gec_max = 20; yabanci_oran = 20; baslat_oran = 20;
         if (r == 2) begin
            for (int n = 0; n < 3; n++) begin
               int a;
               a = int'($urandom_range(0, TL - 1));
               bozuk[a] = 1'b1; bozuk_veri[a] = $urandom;
            end
         end
         baslat_ver();
         calistir(4000);
         model_sonuc(e_adet, e_ilk, e_zaman);
         checks++;
         if (!bitti_gordu) begin failures++; $display("FAIL rand%0d_done got=0 exp=1 (cycle budget)", r); end
         checks++;
         if (kararsiz != 0 || fazla_okuma != 0 || okuma_veri_hata != 0) begin
            failures++; $display("FAIL rand%0d_protocol got unstable=%0d outstanding=%0d rddata=%0d exp 0 0 0",
                                 r, kararsiz, fazla_okuma, okuma_veri_hata);
         end
         checks++;
         if (wr_adr.size() != TL || rd_adr.size() != TL) begin
            failures++; $display("FAIL rand%0d_counts got wr=%0d rd=%0d exp %0d", r, wr_adr.size(), rd_adr.size(), TL);
         end
         for (int k = 0; k < wr_adr.size() && k < rd_adr.size(); k++) begin
            checks++;
            if (wr_adr[k] != k || rd_adr[k] != k || wr_dat[k] !== beklenen(k)) begin
               failures++; $display("FAIL rand%0d_seq[%0d] got wr=%0d rd=%0d dat=%h exp %0d %0d %h",
                                    r, k, wr_adr[k], rd_adr[k], wr_dat[k], k, k, beklenen(k));
            end
         end
         checks++;
         if (hata !== (e_adet != 0) || sayi !== 16'(e_adet) || ilk !== 32'(e_ilk) || zaman !== 1'b0) begin
            failures++; $display("FAIL rand%0d_result got hata=%b sayi=%0d ilk=%0d zaman=%b exp %b %0d %0d 0",
                                 r, hata, sayi, ilk, zaman, e_adet != 0, e_adet, e_ilk);
         end
      end
   endtask

   task automatic test_timeout();
      ayar_sifirla();
      cevapsiz = 3;
      bozuk[1] = 1'b1; bozuk_veri[1] = beklenen(1);
      baslat_ver();
      calistir(400);
      model_sonuc(e_adet, e_ilk, e_zaman);
      checks++;
      if (!bitti_gordu || rd_adr.size() != 4) begin
         failures++; $display("FAIL timeout_done got bitti=%b rd=%0d exp 1 4", bitti_gordu, rd_adr.size());
      end
      // Accept edge plus ZA waiting edges, observed at the following negedge.
      checks++;
      if (son_cyc - cevapsiz_kabul_cyc != ZA + 1) begin
         failures++; $display("FAIL timeout_latency got=%0d exp=%0d", son_cyc - cevapsiz_kabul_cyc, ZA + 1);
      end
      checks++;
      if (zaman !== e_zaman || hata !== 1'b1 || sayi !== 16'(e_adet) || ilk !== 32'(e_ilk)) begin
         failures++; $display("FAIL timeout_result got zaman=%b hata=%b sayi=%0d ilk=%0d exp %b 1 %0d %0d",
                              zaman, hata, sayi, ilk, e_zaman, e_adet, e_ilk);
      end
   endtask

   task automatic test_reset_mid();
      ayar_sifirla();
      bozuk[2] = 1'b1; bozuk_veri[2] = 32'h1234_5678;
      reset_adr = 7;
      baslat_ver();
      calistir(400);
      checks++;
      if (rst !== 1'b1 || rd_adr.size() != 7 || hata !== 1'b1) begin
         failures++; $display("FAIL midreset_reach got rst=%b rd=%0d hata=%b exp 1 7 1", rst, rd_adr.size(), hata);
      end
      @(negedge clk);
      checks++;
      if ({bus.istek_gecerli_o, bus.istek_yaz_o, bus.cevap_hazir_o, bitti, hata, zaman} !== 6'b0 ||
          bus.istek_adres_o !== 32'h0 || bus.istek_veri_o !== 32'h0 || sayi !== 16'h0 || ilk !== 32'h0) begin
         failures++; $display("FAIL midreset_outputs got gv=%b yz=%b ch=%b bt=%b ht=%b za=%b adr=%h sayi=%0d ilk=%0d exp all 0",
                              bus.istek_gecerli_o, bus.istek_yaz_o, bus.cevap_hazir_o, bitti, hata, zaman,
                              bus.istek_adres_o, sayi, ilk);
      end
      rst = 1'b0;
      ayar_sifirla();
      repeat (3) @(negedge clk);
      checks++;
      if (bus.istek_gecerli_o !== 1'b0 || bus.cevap_hazir_o !== 1'b1) begin
         failures++; $display("FAIL midreset_idle got gecerli=%b hazir=%b exp 0 1", bus.istek_gecerli_o, bus.cevap_hazir_o);
      end
      baslat_ver();
      checks++;
      if (bus.istek_gecerli_o !== 1'b1 || bus.istek_yaz_o !== 1'b1 || bus.istek_adres_o !== 32'h0 ||
          bus.istek_veri_o !== beklenen(0)) begin
         failures++; $display("FAIL restart_first got gv=%b yz=%b adr=%h dat=%h exp 1 1 0 %h",
                              bus.istek_gecerli_o, bus.istek_yaz_o, bus.istek_adres_o, bus.istek_veri_o, beklenen(0));
      end
      calistir(400);
      checks++;
      if (!bitti_gordu || wr_adr.size() != TL || hata !== 1'b0 || sayi !== 16'h0 || ilk !== 32'h0) begin
         failures++; $display("FAIL restart_result got bitti=%b wr=%0d hata=%b sayi=%0d ilk=%0d exp 1 %0d 0 0 0",
                              bitti_gordu, wr_adr.size(), hata, sayi, ilk, TL);
      end
   endtask

   initial begin
      bus.istek_hazir_i   = 1'b0;
      bus.cevap_gecerli_i = 1'b0;
      bus.cevap_veri_i    = '0;
      ayar_sifirla();
      test_reset();
      test_ideal();
      test_bozuk();
      test_random();
      test_timeout();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/islemci_trafik_uretici.md
Name: islemci_trafik_uretici

Overview:
Synthesizable processor-side initiator for the onbellek request/response interface. It is the master that drives the cache's islemci_* port.
- Writes a deterministic pattern over TEST_LEN addresses, then reads every address back and compares the returned data.
- Reports done, error flag, error count and first failing address.
- Used in tb_onbellek-class benches and on board as a self-checking traffic source.

Parameters:
TEST_LEN, 16384, number of addresses written then read (>=1)
DESEN_TABAN, 32'hABCD_0000, pattern base; expected data(i) = (DESEN_TABAN + i) & 32'hFFFF_FFFC
ZAMAN_ASIMI, 1024, max cycles waiting for a read response before timeout error

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
baslat_i  in  1  start pulse; sampled in BOSTA and BITTI only
istek_adres_o  out  32  request address (= index i)
istek_veri_o  out  32  write data (= expected data(i)); 0 during reads
istek_gecerli_o  out  1  request valid
istek_yaz_o  out  1  1 = write, 0 = read
istek_hazir_i  in  1  cache accepts request
cevap_veri_i  in  32  read response data
cevap_gecerli_i  in  1  response valid
cevap_hazir_o  out  1  initiator accepts response
bitti_o  out  1  run complete (level, held until restart or reset)
hata_o  out  1  at least one mismatch or timeout in this run
hata_sayisi_o  out  16  mismatch+timeout count, saturates at 16'hFFFF
ilk_hata_adres_o  out  32  index of first failing read; 0 if none
zaman_asimi_o  out  1  sticky; a read response timed out

Behaviour:
- Reset (rst_i high at a posedge) overrides everything, including mid-run:
  - state BOSTA; counter i=0.
  - All outputs 0 except cevap_hazir_o, which is 0 only during reset and 1 otherwise.
- Handshakes:
  - Request transfers on the posedge where istek_gecerli_o && istek_hazir_i.
  - Response transfers on the posedge where cevap_gecerli_i && cevap_hazir_o.
  - Address, data and write bit stay stable while gecerli=1 and hazir=0; gecerli never drops before acceptance.
- States:
  - BOSTA: outputs idle. baslat_i -> clear i, error flag, count, first-error address and timeout flag -> YAZ.
  - YAZ: gecerli=1, yaz=1, addr=i, data=expected(i).
    - On accept: if i==TEST_LEN-1, set i=0 and go to OKU_ISTEK; else i++.
    - Back-to-back writes allowed: a new request is presented the cycle after acceptance.
  - OKU_ISTEK: gecerli=1, yaz=0, addr=i, data=0. On accept -> OKU_BEKLE, clear the timeout counter.
  - OKU_BEKLE: gecerli=0. Exactly one outstanding read.
    - On a response transfer: compare cevap_veri_i with expected(i).
      - Mismatch: hata_o=1, count+1 (saturating); capture i if it is the first error.
    - Then: i==TEST_LEN-1 -> BITTI; else i++ -> OKU_ISTEK.
    - Timeout counter reaches ZAMAN_ASIMI with no response: treated as a mismatch at i, zaman_asimi_o=1 -> BITTI.
  - BITTI: bitti_o=1, gecerli=0, results held. baslat_i -> same clear as in BOSTA -> YAZ, and bitti_o drops.
- Responses arriving outside OKU_BEKLE are accepted (cevap_hazir_o=1) and discarded; the cache's write acknowledgements, if any, never stall.
- A response and a new request never share a cycle: the next read is issued the cycle after the response transfer.
- Width rules:
  - i is $clog2(TEST_LEN)+1 bits, zero-extended onto istek_adres_o.
  - Expected-data addition is 32-bit modulo, then the low 2 bits are masked.
- baslat_i outside BOSTA/BITTI is ignored.

Decomposition:
- Package islemci_trafik_pkg:
  - state enum (BOSTA, YAZ, OKU_ISTEK, OKU_BEKLE, BITTI);
  - function beklenen_veri(taban, i);
  - error-count width constant (16).
- One sub-module, cevap_denetleyici: compares response to expected and maintains error flag, saturating count, first-error capture and timeout counter. The top module keeps the FSM and request path.

Test Plan:
- Ideal responder (hazir=1 always, read response 1 cycle after accept), TEST_LEN=16 -> 16 writes on 16 consecutive cycles, data 0xABCD0000..0xABCD000C (low 2 bits masked); 16 reads; bitti_o=1, hata_o=0, hata_sayisi_o=0.
- Responder corrupts read of addr 5 (returns 0xDEADBEEF) and addr 9 -> hata_o=1, hata_sayisi_o=2, ilk_hata_adres_o=5.
- istek_hazir_i random 30% duty, response latency 0-20 cycles random -> no error; address and data never change while gecerli=1 and hazir=0; never more than one outstanding read.
- Responder never answers read at addr 3, ZAMAN_ASIMI=8 -> 8 cycles after accept: zaman_asimi_o=1, hata_sayisi_o=1, ilk_hata_adres_o=3, bitti_o=1.
- rst_i asserted for 1 cycle during read phase at i=7 -> next cycle all outputs 0 and state BOSTA. A subsequent baslat_i restarts with a write at addr 0 and results are cleared.
- Full system with onbellek + anabellek + bram_model, TEST_LEN=16384 -> bitti_o=1, hata_o=0.
